// File: rtl/quiz_host.sv
// Quiz host controller: latches the buzzer winner, waits for the judge (or a
// timeout), updates saturating per-player scores and then clears the buzzer.
module quiz_host #(
  parameter int SCORE_W      = 4,
  parameter int ANSWER_TICKS = 500
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [2:0]             lights,
  input  logic                   correct,
  input  logic                   wrong,
  output logic                   clear_round,
  output logic [1:0]             winner,
  output logic                   answering,
  output logic [3*SCORE_W-1:0]   scores,
  output logic                   error
);

  typedef enum logic [1:0] {IDLE, ANSWER, CLEAR} state_t;

  localparam int TIMER_W = $clog2(ANSWER_TICKS + 1);

  state_t               state, state_next;
  logic [TIMER_W-1:0]   timer;
  logic                 correct_q, wrong_q;
  logic                 correct_edge, wrong_edge;
  logic                 timeout;
  logic [SCORE_W-1:0]   score [3];
  logic [1:0]           new_winner;
  logic                 inc, dec, illegal;

  assign correct_edge = correct & ~correct_q;
  assign wrong_edge   = wrong & ~wrong_q;
  assign timeout      = (timer == TIMER_W'(ANSWER_TICKS - 1));

  always_comb begin
    state_next = state;
    new_winner = 2'd0;
    inc        = 1'b0;
    dec        = 1'b0;
    illegal    = 1'b0;
    case (state)
      IDLE: begin
        case (lights)
          3'b000: state_next = IDLE;
          3'b001: begin new_winner = 2'd1; state_next = ANSWER; end
          3'b010: begin new_winner = 2'd2; state_next = ANSWER; end
          3'b100: begin new_winner = 2'd3; state_next = ANSWER; end
          default: begin illegal = 1'b1; state_next = CLEAR; end
        endcase
      end
      ANSWER: begin
        // Two edges in one cycle cancel; the timer still runs and may expire.
        if (correct_edge && !wrong_edge) begin
          inc        = 1'b1;
          state_next = CLEAR;
        end else if (wrong_edge && !correct_edge) begin
          dec        = 1'b1;
          state_next = CLEAR;
        end else if (timeout) begin
          dec        = 1'b1;
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        if (lights == 3'b000) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      timer     <= '0;
      correct_q <= 1'b0;
      wrong_q   <= 1'b0;
      winner    <= 2'd0;
      error     <= 1'b0;
      for (int i = 0; i < 3; i++) score[i] <= '0;
    end else begin
      state     <= state_next;
      correct_q <= correct;
      wrong_q   <= wrong;
      if (state == ANSWER) timer <= timer + 1'b1;
      else                 timer <= '0;
      if (state == IDLE && state_next == ANSWER)      winner <= new_winner;
      else if (state == CLEAR && state_next == IDLE)  winner <= 2'd0;
      if (illegal) error <= 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (winner == 2'(i + 1)) begin
          if (inc && score[i] != {SCORE_W{1'b1}}) score[i] <= score[i] + 1'b1;
          if (dec && score[i] != '0)              score[i] <= score[i] - 1'b1;
        end
      end
    end
  end

  assign answering   = reset_n && (state == ANSWER);
  assign clear_round = reset_n && (state == CLEAR);
  assign scores      = {score[2], score[1], score[0]};

endmodule

// File: tb/tb_quiz_host.sv
// Directed bench for quiz_host: one task per scenario, expected values
// written out by hand from the intended behaviour.
module tb_quiz_host;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  lights = 3'b000;
  logic        correct = 1'b0;
  logic        wrong = 1'b0;
  logic        clear_round;
  logic [1:0]  winner;
  logic        answering;
  logic [11:0] scores;
  logic        error;

  int total = 0;
  int passed = 0;

  quiz_host #(.SCORE_W(4), .ANSWER_TICKS(500)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .lights      (lights),
    .correct     (correct),
    .wrong       (wrong),
    .clear_round (clear_round),
    .winner      (winner),
    .answering   (answering),
    .scores      (scores),
    .error       (error)
  );

  always #5 clock = ~clock;

  // Advance one rising edge; inputs change and outputs are read 1 ns after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic answer_round(input logic [2:0] l, input logic good);
    lights = l;
    step();
    lights = 3'b000;
    if (good) correct = 1'b1;
    else      wrong = 1'b1;
    step();
    correct = 1'b0;
    wrong = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    total++; if (scores !== 12'h000) $display("FAIL reset_scores got %h want %h", scores, 12'h000); else passed++;
    total++; if (winner !== 2'd0) $display("FAIL reset_winner got %0d want 0", winner); else passed++;
    total++; if (error !== 1'b0) $display("FAIL reset_error got %b want 0", error); else passed++;
    total++; if ({clear_round, answering} !== 2'b00) $display("FAIL reset_outputs got %b want 00", {clear_round, answering}); else passed++;
    reset_n = 1'b1;
    step();
    total++; if ({clear_round, answering} !== 2'b00) $display("FAIL idle_outputs got %b want 00", {clear_round, answering}); else passed++;
  endtask

  task automatic test_correct();
    lights = 3'b010;
    step();
    total++; if (winner !== 2'd2) $display("FAIL correct_winner got %0d want 2", winner); else passed++;
    total++; if (answering !== 1'b1) $display("FAIL correct_answering got %b want 1", answering); else passed++;
    step();
    correct = 1'b1;
    step();
    correct = 1'b0;
    total++; if (scores !== 12'h010) $display("FAIL correct_score got %h want %h", scores, 12'h010); else passed++;
    total++; if (clear_round !== 1'b1) $display("FAIL correct_clear got %b want 1", clear_round); else passed++;
    step();
    total++; if (clear_round !== 1'b1) $display("FAIL clear_hold got %b want 1", clear_round); else passed++;
    lights = 3'b000;
    step();
    total++; if ({clear_round, answering, winner} !== 4'b0000) $display("FAIL clear_to_idle got %b want 0000", {clear_round, answering, winner}); else passed++;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 16; i++) answer_round(3'b001, 1'b1);
    total++; if (scores !== 12'h01F) $display("FAIL p1_saturate got %h want %h", scores, 12'h01F); else passed++;
    answer_round(3'b100, 1'b0);
    total++; if (scores !== 12'h01F) $display("FAIL p3_floor got %h want %h", scores, 12'h01F); else passed++;
    answer_round(3'b010, 1'b0);
    total++; if (scores !== 12'h00F) $display("FAIL p2_decrement got %h want %h", scores, 12'h00F); else passed++;
  endtask

  task automatic test_timeout();
    lights = 3'b100;
    step();
    lights = 3'b000;
    for (int i = 0; i < 499; i++) step();
    total++; if (answering !== 1'b1) $display("FAIL timeout_early got answering=%b want 1", answering); else passed++;
    step();
    total++; if (clear_round !== 1'b1) $display("FAIL timeout_clear got %b want 1", clear_round); else passed++;
    total++; if (scores !== 12'h00F) $display("FAIL timeout_score got %h want %h", scores, 12'h00F); else passed++;
    step();
  endtask

  task automatic test_simultaneous_held();
    lights = 3'b010;
    step();
    lights = 3'b000;
    correct = 1'b1;
    wrong = 1'b1;
    step();
    total++; if (answering !== 1'b1) $display("FAIL simul_state got answering=%b want 1", answering); else passed++;
    total++; if (scores !== 12'h00F) $display("FAIL simul_score got %h want %h", scores, 12'h00F); else passed++;
    correct = 1'b0;
    wrong = 1'b0;
    step();
    correct = 1'b1;
    for (int i = 0; i < 10; i++) step();
    correct = 1'b0;
    step();
    total++; if (scores !== 12'h01F) $display("FAIL held_score got %h want %h", scores, 12'h01F); else passed++;
    total++; if ({clear_round, answering} !== 2'b00) $display("FAIL held_idle got %b want 00", {clear_round, answering}); else passed++;
  endtask

  task automatic test_judge_idle();
    correct = 1'b1;
    step();
    correct = 1'b0;
    wrong = 1'b1;
    step();
    wrong = 1'b0;
    step();
    total++; if (scores !== 12'h01F) $display("FAIL idle_judge got %h want %h", scores, 12'h01F); else passed++;
  endtask

  task automatic test_illegal();
    lights = 3'b011;
    step();
    total++; if (error !== 1'b1) $display("FAIL illegal_error got %b want 1", error); else passed++;
    total++; if (clear_round !== 1'b1) $display("FAIL illegal_clear got %b want 1", clear_round); else passed++;
    total++; if ({scores, winner} !== {12'h01F, 2'd0}) $display("FAIL illegal_unchanged got %h want %h", {scores, winner}, {12'h01F, 2'd0}); else passed++;
    lights = 3'b000;
    step();
    answer_round(3'b100, 1'b1);
    total++; if (error !== 1'b1) $display("FAIL error_sticky got %b want 1", error); else passed++;
    total++; if (scores !== 12'h11F) $display("FAIL after_illegal got %h want %h", scores, 12'h11F); else passed++;
  endtask

  task automatic test_reset_mid_answer();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    total++; if (error !== 1'b0) $display("FAIL error_cleared got %b want 0", error); else passed++;
    for (int i = 0; i < 3; i++) answer_round(3'b001, 1'b1);
    total++; if (scores !== 12'h003) $display("FAIL p1_three got %h want %h", scores, 12'h003); else passed++;
    lights = 3'b001;
    step();
    total++; if ({answering, winner} !== 3'b101) $display("FAIL mid_answer got %b want 101", {answering, winner}); else passed++;
    reset_n = 1'b0;
    lights = 3'b000;
    correct = 1'b1;
    #1;
    total++; if ({clear_round, answering} !== 2'b00) $display("FAIL reset_gating got %b want 00", {clear_round, answering}); else passed++;
    step();
    correct = 1'b0;
    total++; if ({scores, winner, clear_round} !== 15'h0) $display("FAIL reset_mid got %h want 0", {scores, winner, clear_round}); else passed++;
    reset_n = 1'b1;
    step();
    total++; if ({scores, answering, clear_round} !== 14'h0) $display("FAIL post_reset got %h want 0", {scores, answering, clear_round}); else passed++;
  endtask

  initial begin
    test_reset();
    test_correct();
    test_saturation();
    test_timeout();
    test_simultaneous_held();
    test_judge_idle();
    test_illegal();
    test_reset_mid_answer();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/quiz_host.md
QUIZ_HOST -- requirements
Module: quiz_host

Interface
REQ-001 Parameter SCORE_W, default 4: width of each player score.
REQ-002 Parameter ANSWER_TICKS, default 500: clock cycles allowed for a judge decision (5 s at 100 Hz).
REQ-003 Port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1: reset is synchronous and active-low.
REQ-005 Port lights, input, 3: one-hot winner from the buzzer FSM (bit0 = P1, bit1 = P2, bit2 = P3; 000 = no winner).
REQ-006 Port correct, input, 1: judge "correct" button, level, already synchronous to clock.
REQ-007 Port wrong, input, 1: judge "wrong" button, level, already synchronous to clock.
REQ-008 Port clear_round, output, 1: drives the buzzer FSM's synchronous active-high reset.
REQ-009 Port winner, output, 2: latched answering player (0 = none, 1..3 = P1..P3).
REQ-010 Port answering, output, 1: high while waiting for a judge decision.
REQ-011 Port scores, output, 3*SCORE_W: P1 in [SCORE_W-1:0], P2 next, P3 in the MSBs.
REQ-012 Port error, output, 1: sticky flag for an illegal lights code.

Function
REQ-013 The FSM shall have exactly three states: IDLE, ANSWER, CLEAR.
REQ-014 IDLE transitions:
- lights = 001/010/100 sampled: go to ANSWER on the same edge.
- winner loaded with 1/2/3 accordingly.
- answer timer cleared to 0.
REQ-015 IDLE with any multi-bit lights code (011, 101, 110, 111):
- set error.
- go to CLEAR.
- scores and winner unchanged.
REQ-016 answering shall equal 1 exactly while in ANSWER; clear_round shall equal 1 exactly while in CLEAR (Moore outputs).
REQ-017 Judge rising edges shall be detected as input & ~(input registered one cycle earlier); level holding shall produce one edge only.
REQ-018 ANSWER, correct edge only: the winner's score increments, saturating at 2^SCORE_W-1; go to CLEAR.
REQ-019 ANSWER, wrong edge only: the winner's score decrements, saturating at 0; go to CLEAR.
REQ-020 ANSWER, correct and wrong edges in the same cycle: both ignored, stay in ANSWER, timer keeps counting.
REQ-021 ANSWER timer:
- increments every cycle in ANSWER.
- reaching ANSWER_TICKS-1 with no accepted edge: treat as wrong (REQ-019) and go to CLEAR.
- an edge on the same cycle as timeout takes priority over the timeout.
REQ-022 Changes of lights while in ANSWER shall be ignored; winner stays latched.
REQ-023 CLEAR shall hold clear_round high until lights = 000 is sampled, then go to IDLE on that edge with winner := 0.
REQ-024 Minimum CLEAR duration shall be 1 cycle; there is no upper bound.
REQ-025 Judge edges occurring in IDLE or CLEAR shall be discarded without effect.
REQ-026 Score arithmetic shall be unsigned SCORE_W-bit with no wrap in either direction.

Reset
REQ-027 reset_n = 0 at a rising edge shall force the following, regardless of state:
- state IDLE, scores 0, winner 0, error 0.
- timer 0, edge-detect registers 0.
REQ-028 While reset_n = 0: clear_round = 0, answering = 0.
REQ-029 Reset asserted during ANSWER shall discard the pending decision with no score change.
REQ-030 error shall clear only on reset.

Verification
REQ-031 The bench shall cover the following directed scenarios:
- Correct answer: reset, lights = 010, one edge later correct pulse → winner = 2 and answering = 1 before the pulse; P2 score 0→1; clear_round high until lights = 000, then IDLE.
- Saturation: P1 correct ×16 → P1 score = 15, no wrap; P3 wrong at score 0 → P3 score stays 0.
- Timeout: lights = 100, no judge input → after 500 cycles in ANSWER, P3 score unchanged at 0, clear_round asserted.
- Simultaneous and held input: correct and wrong rising together → no change, still ANSWER; then correct held high 10 cycles → exactly one increment.
- Illegal code: lights = 011 in IDLE → error = 1, scores unchanged, clear_round asserted; error stays 1 until reset_n = 0.
- Reset mid-answer: reset_n low during ANSWER with P1 score 3 → all scores 0, winner 0, clear_round 0 on the following cycle.
